// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse packet tracker.
//   - packet FSM state encoding
//   - header byte bit positions and a decoded header struct
//   - default screen geometry
package mouse_pkg;

  typedef enum logic [1:0] {
    ST_HDR = 2'd0,
    ST_DX  = 2'd1,
    ST_DY  = 2'd2,
    ST_WHL = 2'd3
  } state_t;

  // Header byte bit positions
  localparam int HB_L    = 0;
  localparam int HB_R    = 1;
  localparam int HB_M    = 2;
  localparam int HB_SYNC = 3;  // always 1 in a genuine header
  localparam int HB_XS   = 4;
  localparam int HB_YS   = 5;
  localparam int HB_XO   = 6;
  localparam int HB_YO   = 7;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

  // Header fields kept between the header strobe and the final byte
  typedef struct packed {
    logic yo;
    logic xo;
    logic ys;
    logic xs;
    logic m;
    logic r;
    logic l;
  } hdr_t;

  function automatic hdr_t decode_hdr(input logic [7:0] b);
    hdr_t h;
    h.l  = b[HB_L];
    h.r  = b[HB_R];
    h.m  = b[HB_M];
    h.xs = b[HB_XS];
    h.ys = b[HB_YS];
    h.xo = b[HB_XO];
    h.yo = b[HB_YO];
    return h;
  endfunction

endpackage

// File: rtl/mouse_axis_clamp.sv
// Add a signed delta to an unsigned axis position and clamp to [0, LIMIT-1].
// Ports:
//   pos      - current position (W bits, unsigned)
//   delta    - signed motion, SW bits (SW must leave headroom over W)
//   pos_next - clamped result
module mouse_axis_clamp #(
  parameter int W     = 10,
  parameter int SW    = 12,
  parameter int LIMIT = 640
) (
  input  logic [W-1:0]         pos,
  input  logic signed [SW-1:0] delta,
  output logic [W-1:0]         pos_next
);

  localparam logic signed [SW-1:0] MAXV = SW'(LIMIT - 1);

  logic signed [SW-1:0] sum;

  always_comb begin
    sum = $signed({{(SW-W){1'b0}}, pos}) + delta;
    if (sum[SW-1])        pos_next = '0;
    else if (sum > MAXV)  pos_next = MAXV[W-1:0];
    else                  pos_next = sum[W-1:0];
  end

endmodule

// File: rtl/mouse_packet_tracker.sv
// PS/2 mouse packet decoder and cursor tracker.
// Collects header/dx/dy bytes from a PS/2 receiver, applies scaled and
// clamped motion to an on-screen cursor, and tracks button state.
// Optional macro MOUSE_WHEEL_EN: 4-byte IntelliMouse packets and a
// saturating signed wheel_pos output.
// Ports:
//   CLOCK_50, resetn (async, active low)
//   received_data[7:0], received_data_en   - byte stream from PS/2 rx
//   x_position, y_position                 - cursor (0,0 = top left)
//   left_btn, right_btn, middle_btn        - button levels
//   left_click                             - pulse on left press
//   packet_valid                           - pulse when a packet is applied
//   sync_err_cnt                           - saturating resync counter
//   wheel_pos (MOUSE_WHEEL_EN only)        - wheel accumulator
module mouse_packet_tracker
  import mouse_pkg::*;
#(
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int SENS_SHIFT  = 0,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic [7:0]        received_data,
  input  logic              received_data_en,
  output logic [X_W-1:0]    x_position,
  output logic [Y_W-1:0]    y_position,
  output logic              left_btn,
  output logic              right_btn,
  output logic              middle_btn,
  output logic              left_click,
  output logic              packet_valid,
`ifdef MOUSE_WHEEL_EN
  output logic signed [7:0] wheel_pos,
`endif
  output logic [7:0]        sync_err_cnt
);

  localparam int SW = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT_CYC);

  state_t         state;
  hdr_t           hdr;
  logic [7:0]     dx_byte;
  logic [7:0]     dy_src;
  logic [CW-1:0]  idle_cnt;
  logic           last_byte;

`ifdef MOUSE_WHEEL_EN
  logic [7:0]         dy_byte;
  logic signed [8:0]  wsum;
  assign dy_src    = dy_byte;
  assign last_byte = (state == ST_WHL);
  // 4-bit signed dz widened and added with one bit of headroom
  assign wsum = {wheel_pos[7], wheel_pos} +
                {{5{received_data[3]}}, received_data[3:0]};
`else
  // dy arrives on the final strobe, so it is used straight off the bus
  assign dy_src    = received_data;
  assign last_byte = (state == ST_DY);
`endif

  // Motion deltas: 9-bit two's complement, sensitivity shift, overflow kill.
  // y is negated because PS/2 reports up as positive and row 0 is the top.
  logic signed [8:0]    dx9, dy9, dx_sh, dy_sh;
  logic signed [SW-1:0] dx_e, dy_e, dx_d, dy_d;

  always_comb begin
    dx9   = $signed({hdr.xs, dx_byte});
    dy9   = $signed({hdr.ys, dy_src});
    dx_sh = dx9 >>> SENS_SHIFT;
    dy_sh = dy9 >>> SENS_SHIFT;
    dx_e  = {{(SW-9){dx_sh[8]}}, dx_sh};
    dy_e  = {{(SW-9){dy_sh[8]}}, dy_sh};
    dx_d  = hdr.xo ? '0 : dx_e;
    dy_d  = hdr.yo ? '0 : -dy_e;
  end

  logic [X_W-1:0] x_next;
  logic [Y_W-1:0] y_next;

  mouse_axis_clamp #(.W(X_W), .SW(SW), .LIMIT(SCREEN_W)) u_x_clamp (
    .pos      (x_position),
    .delta    (dx_d),
    .pos_next (x_next)
  );

  mouse_axis_clamp #(.W(Y_W), .SW(SW), .LIMIT(SCREEN_H)) u_y_clamp (
    .pos      (y_position),
    .delta    (dy_d),
    .pos_next (y_next)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_HDR;
      hdr          <= '0;
      dx_byte      <= '0;
      idle_cnt     <= '0;
      x_position   <= X_W'(SCREEN_W / 2);
      y_position   <= Y_W'(SCREEN_H / 2);
      left_btn     <= 1'b0;
      right_btn    <= 1'b0;
      middle_btn   <= 1'b0;
      left_click   <= 1'b0;
      packet_valid <= 1'b0;
      sync_err_cnt <= '0;
`ifdef MOUSE_WHEEL_EN
      dy_byte      <= '0;
      wheel_pos    <= '0;
`endif
    end else begin
      left_click   <= 1'b0;
      packet_valid <= 1'b0;

      if (received_data_en) begin
        idle_cnt <= '0;
        case (state)
          ST_HDR: begin
            if (received_data[HB_SYNC]) begin
              hdr   <= decode_hdr(received_data);
              state <= ST_DX;
            end else if (sync_err_cnt != 8'hFF) begin
              sync_err_cnt <= sync_err_cnt + 8'd1;
            end
          end
          ST_DX: begin
            dx_byte <= received_data;
            state   <= ST_DY;
          end
`ifdef MOUSE_WHEEL_EN
          ST_DY: begin
            dy_byte <= received_data;
            state   <= ST_WHL;
          end
`endif
          default: state <= ST_HDR;  // final byte of the packet
        endcase

        if (last_byte) begin
          x_position   <= x_next;
          y_position   <= y_next;
          left_btn     <= hdr.l;
          right_btn    <= hdr.r;
          middle_btn   <= hdr.m;
          left_click   <= hdr.l & ~left_btn;
          packet_valid <= 1'b1;
`ifdef MOUSE_WHEEL_EN
          if (wsum > 9'sd127)        wheel_pos <= 8'sd127;
          else if (wsum < -9'sd128)  wheel_pos <= -8'sd128;
          else                       wheel_pos <= wsum[7:0];
`endif
        end
      end else if (state != ST_HDR && idle_cnt == TO) begin
        // Stalled mid-packet: drop it and wait for a fresh header
        state    <= ST_HDR;
        idle_cnt <= '0;
        if (sync_err_cnt != 8'hFF) sync_err_cnt <= sync_err_cnt + 8'd1;
      end else if (idle_cnt != TO) begin
        idle_cnt <= idle_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mouse_packet_tracker.sv
// Testbench for mouse_packet_tracker (default 3-byte build).
// Directed packet scenarios followed by randomized byte streams, all
// compared against a packet-level reference model every clock.
module tb_mouse_packet_tracker;

  localparam int T  = 50;
  localparam int SW = 640;
  localparam int SH = 480;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic [9:0] x_position;
  logic [8:0] y_position;
  logic       left_btn, right_btn, middle_btn, left_click, packet_valid;
  logic [7:0] sync_err_cnt;
`ifdef MOUSE_WHEEL_EN
  logic signed [7:0] wheel_pos;
`endif

  mouse_packet_tracker #(.TIMEOUT_CYC(T)) dut (
    .CLOCK_50         (CLOCK_50),
    .resetn           (resetn),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .x_position       (x_position),
    .y_position       (y_position),
    .left_btn         (left_btn),
    .right_btn        (right_btn),
    .middle_btn       (middle_btn),
    .left_click       (left_click),
    .packet_valid     (packet_valid),
`ifdef MOUSE_WHEEL_EN
    .wheel_pos        (wheel_pos),
`endif
    .sync_err_cnt     (sync_err_cnt)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference model: packet bytes collected in a queue, applied as a whole
  int   mx, my, merr, idle;
  bit   ml, mr, mm, mclk, mpv;
  byte unsigned pkt[$];

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    mx = SW / 2; my = SH / 2; merr = 0; idle = 0;
    ml = 0; mr = 0; mm = 0; mclk = 0; mpv = 0;
    pkt.delete();
  endtask

  task automatic model_apply();
    byte unsigned h;
    int dx, dy;
    h  = pkt[0];
    dx = h[4] ? int'(pkt[1]) - 256 : int'(pkt[1]);
    dy = h[5] ? int'(pkt[2]) - 256 : int'(pkt[2]);
    if (h[6]) dx = 0;
    if (h[7]) dy = 0;
    mx   = clampi(mx + dx, SW - 1);
    my   = clampi(my - dy, SH - 1);
    mclk = h[0] && !ml;
    ml = h[0]; mr = h[1]; mm = h[2];
    mpv  = 1;
    pkt.delete();
  endtask

  task automatic model_step(input bit en, input byte unsigned d);
    mpv = 0; mclk = 0;
    if (en) begin
      idle = 0;
      if (pkt.size() == 0 && !d[3]) begin
        if (merr < 255) merr++;
      end else begin
        pkt.push_back(d);
        if (pkt.size() == 3) model_apply();
      end
    end else if (pkt.size() != 0 && idle >= T) begin
      // TIMEOUT_CYC idle cycles already elapsed mid-packet: drop it
      pkt.delete();
      if (merr < 255) merr++;
      idle = 0;
    end else begin
      idle++;
    end
  endtask

  task automatic check_outputs();
    chk("x_position",   int'(x_position),   mx);
    chk("y_position",   int'(y_position),   my);
    chk("buttons",      int'({middle_btn, right_btn, left_btn}), int'({mm, mr, ml}));
    chk("left_click",   int'(left_click),   int'(mclk));
    chk("packet_valid", int'(packet_valid), int'(mpv));
    chk("sync_err_cnt", int'(sync_err_cnt), merr);
  endtask

  // One clock: drive at negedge, let the posedge act, check at next negedge
  task automatic cycle(input bit en, input logic [7:0] d);
    received_data_en = en;
    received_data    = d;
    @(negedge CLOCK_50);
    received_data_en = 1'b0;
    model_step(en, d);
    check_outputs();
  endtask

  task automatic send(input logic [7:0] d);
    cycle(1'b1, d);
  endtask

  task automatic gap(input int n);
    repeat (n) cycle(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    received_data_en = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge CLOCK_50);
    resetn = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    @(negedge CLOCK_50);

    // Basic motion
    do_reset();
    send(8'h08); send(8'h05);
    send(8'h03);
    chk("basic_x", int'(x_position), 325);
    chk("basic_y", int'(y_position), 237);
    chk("basic_pv", int'(packet_valid), 1);
    gap(1);
    chk("basic_pv_drop", int'(packet_valid), 0);

    // Left press produces one click; holding it does not
    send(8'h09); send(8'h00); send(8'h00);
    chk("click_pulse", int'(left_click), 1);
    chk("click_btn", int'(left_btn), 1);
    gap(1);
    chk("click_one_cycle", int'(left_click), 0);
    send(8'h09); send(8'h00); send(8'h00);
    chk("click_held", int'(left_click), 0);

    // Large negative dx clamps at column 0
    do_reset();
    repeat (4) begin send(8'h18); send(8'h80); send(8'h00); end
    chk("clamp_x0", int'(x_position), 0);

    // Bad header rejected, following packet applied
    do_reset();
    send(8'h00); send(8'h08); send(8'h05); send(8'h03);
    chk("resync_err", int'(sync_err_cnt), 1);
    chk("resync_x", int'(x_position), 325);

    // Mid-packet timeout
    do_reset();
    send(8'h08); send(8'h05);
    gap(T + 2);
    send(8'h08); send(8'h01); send(8'h01);
    chk("timeout_err", int'(sync_err_cnt), 1);
    chk("timeout_x", int'(x_position), 321);
    chk("timeout_y", int'(y_position), 239);

    // Idle gap of exactly TIMEOUT_CYC cycles does not drop the packet
    do_reset();
    send(8'h08); gap(T); send(8'h02); send(8'h00);
    chk("edge_err", int'(sync_err_cnt), 0);
    chk("edge_x", int'(x_position), 322);

    // X overflow kills x motion only
    do_reset();
    send(8'h48); send(8'hFF); send(8'h02);
    chk("ovf_x", int'(x_position), 320);
    chk("ovf_y", int'(y_position), 238);

    // Reset mid-packet: next byte is a header
    do_reset();
    send(8'h08); send(8'h05);
    do_reset();
    send(8'h08); send(8'h01); send(8'h01);
    chk("rst_mid_x", int'(x_position), 321);
    chk("rst_mid_y", int'(y_position), 239);

    // Error counter saturation
    do_reset();
    repeat (300) send(8'h00);
    chk("err_sat", int'(sync_err_cnt), 255);

    // Randomized stream
    do_reset();
    repeat (2000) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) != 0) b[3] = 1'b1;
      if ($urandom_range(0, 3) != 0) b[7:6] = 2'b00;
      send(b);
      if ($urandom_range(0, 99) < 3) gap($urandom_range(T - 1, T + 1));
      else gap($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
